// File: rtl/idu_pkg.sv
// Shared types for the RV32 decode stage: opcodes, format codes and the
// decoded payload carried through the skid buffer.
package idu_pkg;

  // Widest passthrough PC the payload can carry; idu_stage requires PC_W <= PC_MAX_W.
  localparam int PC_MAX_W = 32;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [6:0]          op;
    logic [2:0]          func3;
    logic [6:0]          func7;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [31:0]         imm;
    fmt_e                fmt;
    logic                illegal;
  } idu_payload_t;

  function automatic fmt_e opcode_fmt(input logic [6:0] op);
    fmt_e f;
    case (op)
      OPC_OP:                                    f = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR,
      OPC_SYSTEM, OPC_MISC_MEM:                  f = FMT_I;
      OPC_STORE:                                 f = FMT_S;
      OPC_BRANCH:                                f = FMT_B;
      OPC_LUI, OPC_AUIPC:                        f = FMT_U;
      OPC_JAL:                                   f = FMT_J;
      default:                                   f = FMT_ILL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/idu_decode.sv
// Combinational RV32I/RV32E field extraction, immediate generation and
// illegal-instruction detection.
module idu_decode
  import idu_pkg::*;
#(
  parameter int NR_REG = 32
) (
  input  logic [31:0]         inst_i,
  input  logic [PC_MAX_W-1:0] pc_i,
  output idu_payload_t        dec_o
);

  fmt_e        fmt;
  logic [31:0] imm;
  logic        use_rd;
  logic        use_rs1;
  logic        use_rs2;
  logic        rv32e_bad;

  always_comb begin
    fmt     = opcode_fmt(inst_i[6:0]);
    imm     = '0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (fmt)
      FMT_R: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      FMT_I: begin
        imm     = {{20{inst_i[31]}}, inst_i[31:20]};
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      FMT_S: begin
        imm     = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      FMT_B: begin
        imm     = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      FMT_U: begin
        imm    = {inst_i[31:12], 12'b0};
        use_rd = 1'b1;
      end
      FMT_J: begin
        imm    = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
        use_rd = 1'b1;
      end
      default: ;
    endcase

    // RV32E: only register fields the format actually uses may name x16..x31.
    rv32e_bad = (NR_REG == 16) &&
                ((use_rd && inst_i[11]) || (use_rs1 && inst_i[19]) || (use_rs2 && inst_i[24]));

    dec_o         = '0;
    dec_o.pc      = pc_i;
    dec_o.op      = inst_i[6:0];
    dec_o.func3   = inst_i[14:12];
    dec_o.func7   = inst_i[31:25];
    dec_o.rs1     = inst_i[19:15];
    dec_o.rs2     = inst_i[24:20];
    dec_o.rd      = inst_i[11:7];
    dec_o.imm     = imm;
    dec_o.fmt     = fmt;
    dec_o.illegal = (fmt == FMT_ILL) ||
                    ((inst_i[6:0] == OPC_JALR) && (inst_i[14:12] != 3'b000)) ||
                    rv32e_bad;
  end

endmodule

// File: rtl/idu_stage.sv
// Registered decode stage: one-cycle latency, 2-entry skid buffer (main M,
// skid S) so o_ready can come straight from a flop without losing throughput.
module idu_stage
  import idu_pkg::*;
#(
  parameter int NR_REG = 32,
  parameter int PC_W   = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_inst,
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [PC_W-1:0] o_pc,
  output logic [6:0]      o_op,
  output logic [2:0]      o_func3,
  output logic [6:0]      o_func7,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [31:0]     o_imm,
  output logic [2:0]      o_fmt,
  output logic            o_illegal
);

  idu_payload_t dec_w;
  idu_payload_t m_data_q, m_data_d;
  idu_payload_t s_data_q, s_data_d;
  logic         m_valid_q, m_valid_d;
  logic         s_valid_q, s_valid_d;
  logic         ready_q, ready_d;
  logic         accept;
  logic         drain;

  idu_decode #(.NR_REG(NR_REG)) u_decode (
    .inst_i (i_inst),
    .pc_i   (PC_MAX_W'(i_pc)),
    .dec_o  (dec_w)
  );

  always_comb begin
    accept    = i_valid & ready_q & ~i_flush;
    drain     = m_valid_q & i_ready;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    if (i_flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || drain) begin
      // S is only ever valid behind a valid M, and accept is blocked while S is full.
      if (s_valid_q) begin
        m_data_d  = s_data_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_data_d  = dec_w;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_data_d  = dec_w;
      s_valid_d = 1'b1;
    end
    ready_d = ~s_valid_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      ready_q   <= 1'b1;
      m_data_q  <= '0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      ready_q   <= ready_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = m_valid_q;
  assign o_pc      = m_data_q.pc[PC_W-1:0];
  assign o_op      = m_data_q.op;
  assign o_func3   = m_data_q.func3;
  assign o_func7   = m_data_q.func7;
  assign o_rs1     = m_data_q.rs1;
  assign o_rs2     = m_data_q.rs2;
  assign o_rd      = m_data_q.rd;
  assign o_imm     = m_data_q.imm;
  assign o_fmt     = m_data_q.fmt;
  assign o_illegal = m_data_q.illegal;

endmodule

// File: tb/tb_idu_stage.sv
// Directed bench for idu_stage: decode vectors (RV32I and RV32E instances),
// backpressure ordering, flush and asynchronous mid-stream reset.
module tb_idu_stage;

  logic        clock   = 1'b0;
  logic        reset   = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_ready = 1'b0;
  logic [31:0] i_inst  = '0;
  logic [31:0] i_pc    = '0;

  logic        o_ready, o_valid, o_illegal;
  logic [31:0] o_pc, o_imm;
  logic [6:0]  o_op, o_func7;
  logic [2:0]  o_func3, o_fmt;
  logic [4:0]  o_rs1, o_rs2, o_rd;

  logic        e_ready, e_valid, e_illegal;
  logic [31:0] e_pc, e_imm;
  logic [6:0]  e_op, e_func7;
  logic [2:0]  e_func3, e_fmt;
  logic [4:0]  e_rs1, e_rs2, e_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  idu_stage #(.NR_REG(32), .PC_W(32)) dut (
    .clock(clock), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_inst(i_inst), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .o_pc(o_pc), .o_op(o_op), .o_func3(o_func3),
    .o_func7(o_func7), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd),
    .o_imm(o_imm), .o_fmt(o_fmt), .o_illegal(o_illegal)
  );

  idu_stage #(.NR_REG(16), .PC_W(32)) dut_e (
    .clock(clock), .reset(reset), .i_valid(i_valid), .o_ready(e_ready),
    .i_inst(i_inst), .i_pc(i_pc), .i_flush(i_flush), .o_valid(e_valid),
    .i_ready(i_ready), .o_pc(e_pc), .o_op(e_op), .o_func3(e_func3),
    .o_func7(e_func7), .o_rs1(e_rs1), .o_rs2(e_rs2), .o_rd(e_rd),
    .o_imm(e_imm), .o_fmt(e_fmt), .o_illegal(e_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    i_valid = 1'b1;
    i_inst  = inst;
    i_pc    = pc;
  endtask

  task automatic beat(input logic [31:0] inst, input logic [31:0] pc);
    drive(inst, pc);
    step();
    i_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, released mid-cycle
    #12 reset = 1'b0;
    check("rst_valid",   32'(o_valid),   32'd0);
    check("rst_ready",   32'(o_ready),   32'd1);
    check("rst_pc",      o_pc,           32'd0);
    check("rst_imm",     o_imm,          32'd0);
    check("rst_fmt",     32'(o_fmt),     32'd0);
    check("rst_illegal", 32'(o_illegal), 32'd0);

    // Decode vectors, i_ready=1
    i_ready = 1'b1;
    beat(32'hFFF00093, 32'h100);                // addi x1,x0,-1
    check("addi_valid",   32'(o_valid),   32'd1);
    check("addi_pc",      o_pc,           32'h100);
    check("addi_op",      32'(o_op),      32'h13);
    check("addi_fmt",     32'(o_fmt),     32'd1);
    check("addi_rd",      32'(o_rd),      32'd1);
    check("addi_rs1",     32'(o_rs1),     32'd0);
    check("addi_imm",     o_imm,          32'hFFFFFFFF);
    check("addi_illegal", 32'(o_illegal), 32'd0);

    beat(32'h008000EF, 32'h104);                // jal x1,8
    check("jal_fmt", 32'(o_fmt), 32'd5);
    check("jal_imm", o_imm,      32'h00000008);

    beat(32'hFE000EE3, 32'h108);                // beq x0,x0,-4
    check("beq_fmt", 32'(o_fmt), 32'd3);
    check("beq_imm", o_imm,      32'hFFFFFFFC);

    beat(32'hFE20AC23, 32'h10C);                // sw x2,-8(x1)
    check("sw_fmt",   32'(o_fmt),   32'd2);
    check("sw_imm",   o_imm,        32'hFFFFFFF8);
    check("sw_rs1",   32'(o_rs1),   32'd1);
    check("sw_rs2",   32'(o_rs2),   32'd2);
    check("sw_func3", 32'(o_func3), 32'd2);

    beat(32'h123452B7, 32'h110);                // lui x5,0x12345
    check("lui_fmt", 32'(o_fmt), 32'd4);
    check("lui_imm", o_imm,      32'h12345000);
    check("lui_rd",  32'(o_rd),  32'd5);

    beat(32'h011000B3, 32'h114);                // add x1,x0,x17
    check("add_fmt",       32'(o_fmt),     32'd0);
    check("add_imm",       o_imm,          32'd0);
    check("add_rs2",       32'(o_rs2),     32'd17);
    check("add_i_illegal", 32'(o_illegal), 32'd0);
    check("add_e_rs2",     32'(e_rs2),     32'd17);
    check("add_e_illegal", 32'(e_illegal), 32'd1);

    beat(32'hFFDFF0EF, 32'h118);                // jal x1,-4: imm bits sit in rs fields
    check("jalm4_imm",       o_imm,          32'hFFFFFFFC);
    check("jalm4_e_illegal", 32'(e_illegal), 32'd0);

    beat(32'h000090E7, 32'h11C);                // jalr with func3=1
    check("jalr3_fmt",     32'(o_fmt),     32'd1);
    check("jalr3_illegal", 32'(o_illegal), 32'd1);

    beat(32'h000080E7, 32'h120);                // jalr x1,0(x1)
    check("jalr0_illegal", 32'(o_illegal), 32'd0);

    beat(32'h0000007F, 32'h124);                // reserved opcode
    check("ill_fmt",     32'(o_fmt),     32'd7);
    check("ill_illegal", 32'(o_illegal), 32'd1);
    check("ill_imm",     o_imm,          32'd0);
    check("ill_valid",   32'(o_valid),   32'd1);

    step();
    check("idle_valid", 32'(o_valid), 32'd0);

    // Backpressure: i_ready low for 3 cycles while streaming PCs 0,4,8,...
    i_ready = 1'b0;
    drive(32'h00000013, 32'd0);
    step();
    check("bp_pc0",     o_pc,           32'd0);
    check("bp_ready1",  32'(o_ready),   32'd1);
    drive(32'h00000013, 32'd4);
    step();
    check("bp_ready2",  32'(o_ready),   32'd0);
    check("bp_hold_a",  o_pc,           32'd0);
    drive(32'h00000013, 32'd8);
    step();
    check("bp_hold_b",  o_pc,           32'd0);
    check("bp_valid",   32'(o_valid),   32'd1);
    i_ready = 1'b1;
    step();
    check("bp_out4",    o_pc,           32'd4);
    check("bp_ready_r", 32'(o_ready),   32'd1);
    step();
    check("bp_out8",    o_pc,           32'd8);
    drive(32'h00000013, 32'd12);
    step();
    check("bp_out12",   o_pc,           32'd12);
    drive(32'h00000013, 32'd16);
    step();
    check("bp_out16",   o_pc,           32'd16);
    i_valid = 1'b0;
    step();
    check("bp_drained", 32'(o_valid),   32'd0);

    // Flush with M and S full plus an input beat
    i_ready = 1'b0;
    beat(32'h00000013, 32'h40);
    beat(32'h00000013, 32'h44);
    check("fl_full_ready", 32'(o_ready), 32'd0);
    drive(32'h00000013, 32'h48);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("fl_valid", 32'(o_valid), 32'd0);
    check("fl_ready", 32'(o_ready), 32'd1);
    i_ready = 1'b1;
    step();
    check("fl_gone_a", 32'(o_valid), 32'd0);
    step();
    check("fl_gone_b", 32'(o_valid), 32'd0);

    // Flush with only M full: o_ready=1, yet the input beat is dropped
    i_ready = 1'b0;
    beat(32'h00000013, 32'h50);
    drive(32'h00000013, 32'h54);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("fl2_valid", 32'(o_valid), 32'd0);
    i_ready = 1'b1;
    step();
    check("fl2_gone", 32'(o_valid), 32'd0);

    // Mid-stream asynchronous reset between edges
    i_ready = 1'b0;
    beat(32'h00000013, 32'h80);
    drive(32'h00000013, 32'h84);
    step();
    i_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("mrst_valid", 32'(o_valid), 32'd0);
    check("mrst_ready", 32'(o_ready), 32'd1);
    check("mrst_pc",    o_pc,         32'd0);
    check("mrst_fmt",   32'(o_fmt),   32'd0);
    #2 reset = 1'b0;
    i_ready = 1'b1;
    beat(32'hFFF00093, 32'h200);
    check("post_valid", 32'(o_valid), 32'd1);
    check("post_pc",    o_pc,         32'h200);
    check("post_imm",   o_imm,        32'hFFFFFFFF);
    step();
    check("post_empty", 32'(o_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
